// File: rtl/lift_pkg.sv
// Shared definitions for the hall-call dispatcher: call codes, button
// indices, floor encodings, FSM states and index-to-code/floor helpers.
package lift_pkg;

    // Request codes understood by the lift FSM
    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_1U   = 3'b001;
    localparam logic [2:0] C_2U   = 3'b010;
    localparam logic [2:0] C_3U   = 3'b011;
    localparam logic [2:0] C_2D   = 3'b110;
    localparam logic [2:0] C_3D   = 3'b111;
    localparam logic [2:0] C_4D   = 3'b100;

    // Bit positions of the hall buttons in btn / pending
    localparam logic [2:0] IDX_1U = 3'd0;
    localparam logic [2:0] IDX_2U = 3'd1;
    localparam logic [2:0] IDX_3U = 3'd2;
    localparam logic [2:0] IDX_2D = 3'd3;
    localparam logic [2:0] IDX_3D = 3'd4;
    localparam logic [2:0] IDX_4D = 3'd5;

    // Floor encodings reported by the lift FSM
    localparam logic [1:0] FLOOR_1 = 2'b00;
    localparam logic [1:0] FLOOR_2 = 2'b01;
    localparam logic [1:0] FLOOR_3 = 2'b10;
    localparam logic [1:0] FLOOR_4 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DWELL
    } state_e;

    function automatic logic [2:0] idx2code(input logic [2:0] idx);
        case (idx)
            IDX_1U:  return C_1U;
            IDX_2U:  return C_2U;
            IDX_3U:  return C_3U;
            IDX_2D:  return C_2D;
            IDX_3D:  return C_3D;
            IDX_4D:  return C_4D;
            default: return C_NONE;
        endcase
    endfunction

    function automatic logic [1:0] idx2floor(input logic [2:0] idx);
        case (idx)
            IDX_1U:          return FLOOR_1;
            IDX_2U, IDX_2D:  return FLOOR_2;
            IDX_3U, IDX_3D:  return FLOOR_3;
            IDX_4D:          return FLOOR_4;
            default:         return FLOOR_1;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter6.sv
// Combinational round-robin picker over the six hall calls. The search
// starts one position after ptr_i and wraps modulo 6; first set bit wins.
module rr_arbiter6 (
    input  logic [5:0] req_i,
    input  logic [2:0] ptr_i,
    output logic       grant_valid_o,
    output logic [2:0] grant_idx_o
);

    logic [2:0] idx;

    // Scan the six positions in priority order starting after the pointer
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        grant_valid_o = 1'b0;
        grant_idx_o   = 3'd0;
        idx           = 3'd0;
        for (int k = 1; k <= 6; k++) begin
            idx = 3'((int'(ptr_i) + k) % 6);
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx;
            end
        end
    end

endmodule

// File: rtl/hall_call_dispatcher.sv
// Hall-call dispatcher for a 4-floor lift: latches hall buttons, grants one
// call at a time round-robin, holds it until the lift idles at that floor,
// then waits a door dwell before the next grant.
// Optional macro HALL_CALL_TIMEOUT_EN abandons a call after TIMEOUT_CYCLES
// in WAIT (call stays pending, one-cycle timeout_pulse).
module hall_call_dispatcher
    import lift_pkg::*;
#(
    parameter int DWELL_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn,
    input  logic [1:0] lift_floor,
    input  logic       lift_idle,
    output logic [2:0] req_code,
    output logic       req_valid,
    output logic [5:0] pending,
    output logic       busy,
    output logic       timeout_pulse
);

    localparam int DW_W = $clog2(DWELL_CYCLES + 1);

    // Reject parameter values outside the supported ranges at elaboration
    if (DWELL_CYCLES < 1 || DWELL_CYCLES > 255) begin : g_bad_dwell
        $error("DWELL_CYCLES must be in 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_e          state_q;
    logic [5:0]      pending_q, pending_d;
    logic [2:0]      rr_ptr_q;
    logic [2:0]      grant_idx_q;
    logic [2:0]      req_code_q;
    logic            req_valid_q;
    logic            busy_q;
    logic [DW_W-1:0] dwell_cnt_q;
    logic            arrive;
    logic            grant_valid;
    logic [2:0]      grant_idx;

    rr_arbiter6 u_arb (
        .req_i         (pending_q),
        .ptr_i         (rr_ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    assign arrive = (state_q == S_WAIT) && lift_idle
                    && (lift_floor == idx2floor(grant_idx_q));

    // Next pending set: new presses OR in, served call cleared (clear wins)
    always_comb begin
        pending_d = pending_q | btn;
        if (arrive) begin
            pending_d[grant_idx_q] = 1'b0;
        end
    end

    // Pending-call register (hall lamps)
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

`ifdef HALL_CALL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_pulse_q;
    assign timeout_pulse = timeout_pulse_q;
`else
    assign timeout_pulse = 1'b0;
`endif

    // Dispatcher FSM with registered request/busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rr_ptr_q        <= IDX_4D;
            grant_idx_q     <= 3'd0;
            req_code_q      <= C_NONE;
            req_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            dwell_cnt_q     <= '0;
`ifdef HALL_CALL_TIMEOUT_EN
            to_cnt_q        <= '0;
            timeout_pulse_q <= 1'b0;
`endif
        end else begin
`ifdef HALL_CALL_TIMEOUT_EN
            timeout_pulse_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (grant_valid) begin
                        state_q     <= S_WAIT;
                        grant_idx_q <= grant_idx;
                        rr_ptr_q    <= grant_idx;
                        req_code_q  <= idx2code(grant_idx);
                        req_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
`ifdef HALL_CALL_TIMEOUT_EN
                        to_cnt_q    <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (arrive) begin
                        state_q     <= S_DWELL;
                        req_code_q  <= C_NONE;
                        req_valid_q <= 1'b0;
                        dwell_cnt_q <= DW_W'(DWELL_CYCLES - 1);
                    end
`ifdef HALL_CALL_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q         <= S_IDLE;
                        req_code_q      <= C_NONE;
                        req_valid_q     <= 1'b0;
                        busy_q          <= 1'b0;
                        timeout_pulse_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                S_DWELL: begin
                    if (dwell_cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_code  = req_code_q;
    assign req_valid = req_valid_q;
    assign busy      = busy_q;
    assign pending   = pending_q;

endmodule
